trdb_branch_map_unpacker: RTL and testbench

- Receive side of the branch-map path. Accepts one packed branch map with its branch count, as produced by the trace encoder's branch map.
- Replays the stored outcomes one per handshake, oldest first, to the decoder's instruction-reconstruction logic.
- Holds at most one map. A new map is accepted only when the previous one is fully drained.

---
 rtl/trdb_branch_map_unpacker.sv | 99 +++++++++
 tb/tb_trdb_branch_map_unpacker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_branch_map_unpacker.sv
// Receive side of the branch-map path: holds one packed branch map and replays
// its outcomes one per handshake, oldest first, to the instruction reconstructor.
module trdb_branch_map_unpacker #(
   parameter int MAP_LEN = 31,
   parameter int CNT_W   = 5
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               load_valid_i,
   output logic               load_ready_o,
   input  logic [MAP_LEN-1:0] map_i,
   input  logic [CNT_W-1:0]   branches_i,
   output logic               br_valid_o,
   input  logic               br_ready_i,
   output logic               br_taken_o,
   output logic [CNT_W-1:0]   remaining_o,
   output logic               done_o,
   output logic               err_o
);

   typedef enum logic {IDLE, REPLAY} state_t;

   localparam logic [CNT_W:0] MAP_LEN_C = (CNT_W+1)'(MAP_LEN);

   state_t             state_reg;
   logic [MAP_LEN-1:0] shift_reg;
   logic [CNT_W-1:0]   remaining_reg;
   logic               done_reg;
   logic               err_reg;

   logic               over_len;
   logic [CNT_W-1:0]   load_cnt;
   logic [MAP_LEN-1:0] load_mask;

   assign over_len = {1'b0, branches_i} > MAP_LEN_C;
   assign load_cnt = over_len ? MAP_LEN_C[CNT_W-1:0] : branches_i;

   // Bits above the count are zeroed on capture so the register drains to 0.
   genvar gi;
   generate
      for (gi = 0; gi < MAP_LEN; gi++) begin : g_mask
         assign load_mask[gi] = (32'(load_cnt) > 32'(gi));
      end
   endgenerate

   assign load_ready_o = (state_reg == IDLE) && !flush_i;
   assign br_valid_o   = (state_reg == REPLAY);
   assign br_taken_o   = shift_reg[0];
   assign remaining_o  = remaining_reg;
   assign done_o       = done_reg;
   assign err_o        = err_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         shift_reg     <= '0;
         remaining_reg <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush_i) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            remaining_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (load_valid_i) begin
                     if (over_len)
                        err_reg <= 1'b1;
                     // An empty map is accepted and acknowledged with done only.
                     if (branches_i == '0) begin
                        done_reg <= 1'b1;
                     end else begin
                        shift_reg     <= map_i & load_mask;
                        remaining_reg <= load_cnt;
                        state_reg     <= REPLAY;
                     end
                  end
               end
               REPLAY: begin
                  if (br_ready_i) begin
                     shift_reg     <= shift_reg >> 1;
                     remaining_reg <= remaining_reg - 1'b1;
                     if (remaining_reg == CNT_W'(1)) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                     end
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trdb_branch_map_unpacker.sv
// Randomized and directed bench for trdb_branch_map_unpacker, checked against
// a queue-based model of the outcomes still owed to the consumer.
module tb_trdb_branch_map_unpacker;

   localparam int M = 31;
   localparam int W = 5;

   logic          clk;
   logic          rst_n;
   logic          flush, load_valid, load_ready;
   logic [M-1:0]  map;
   logic [W-1:0]  branches;
   logic          br_valid, br_ready, br_taken;
   logic [W-1:0]  remaining;
   logic          done, err;

   logic          rst20_n;
   logic          flush20, l20_valid, l20_ready;
   logic [19:0]   map20;
   logic [W-1:0]  br20;
   logic          v20, r20_ready, t20;
   logic [W-1:0]  rem20;
   logic          d20, e20;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   bit cmp_en   = 0;

   bit m_q[$];
   bit m_done;
   bit m_err;
   int m_n;

   trdb_branch_map_unpacker #(.MAP_LEN(M), .CNT_W(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .load_valid_i(load_valid), .load_ready_o(load_ready),
      .map_i(map), .branches_i(branches),
      .br_valid_o(br_valid), .br_ready_i(br_ready), .br_taken_o(br_taken),
      .remaining_o(remaining), .done_o(done), .err_o(err)
   );

   trdb_branch_map_unpacker #(.MAP_LEN(20), .CNT_W(W)) dut20 (
      .clk_i(clk), .rst_ni(rst20_n), .flush_i(flush20),
      .load_valid_i(l20_valid), .load_ready_o(l20_ready),
      .map_i(map20), .branches_i(br20),
      .br_valid_o(v20), .br_ready_i(r20_ready), .br_taken_o(t20),
      .remaining_o(rem20), .done_o(d20), .err_o(e20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Model: the queue holds exactly the outcomes not yet handed over.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_done = 0;
         m_err  = 0;
      end else if (flush) begin
         m_q.delete();
         m_done = 0;
      end else if (m_q.size() == 0) begin
         m_done = 0;
         if (load_valid) begin
            m_n = (int'(branches) > M) ? M : int'(branches);
            if (int'(branches) > M) m_err = 1;
            for (int i = 0; i < m_n; i++) m_q.push_back(map[i]);
            m_done = (m_n == 0);
         end
      end else begin
         m_done = 0;
         if (br_ready) begin
            void'(m_q.pop_front());
            m_done = (m_q.size() == 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("valid", br_valid, m_q.size() != 0);
         if (m_q.size() != 0) chk("taken", br_taken, m_q[0]);
         chk("remaining", remaining, m_q.size());
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("load_ready", load_ready, (m_q.size() == 0) && !flush);
      end
   end

   always @(negedge clk) if (rst_n && done) done_cnt++;

   initial begin
      logic [3:0]  seq_a;
      logic [6:0]  pat_b;
      logic [2:0]  seq_c;
      logic [31:0] rnd;
      int hs, done_base, cnt;
      bit done_seen;

      rst_n = 0; rst20_n = 0;
      flush = 0; load_valid = 0; map = '0; branches = '0; br_ready = 0;
      flush20 = 0; l20_valid = 0; map20 = '0; br20 = '0; r20_ready = 0;
      seq_a = 4'b1011;
      pat_b = 7'b1101001;   // applied from bit 0: 1,0,0,1,0,1,1
      seq_c = 3'b010;

      #12;
      chk("rst_valid", br_valid, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_taken", br_taken, 0);
      chk("rst20_valid", v20, 0);
      @(posedge clk); #2;
      rst_n = 1; rst20_n = 1; cmp_en = 1;

      // A: 0b1011, four outcomes, consumer always ready
      load_valid = 1; map = 31'b1011; branches = 4; br_ready = 1;
      step();
      load_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("A_taken", br_taken, seq_a[i]);
         chk("A_remaining", remaining, 4 - i);
      end
      @(negedge clk); #1;
      chk("A_done", done, 1);
      chk("A_load_ready", load_ready, 1);

      // B: same map with consumer stalls
      step();
      load_valid = 1; br_ready = 0;
      step();
      load_valid = 0;
      done_base = done_cnt;
      hs = 0;
      for (int i = 0; i < 7; i++) begin
         br_ready = pat_b[i];
         @(negedge clk); #1;
         if (br_valid && br_ready) hs++;
         step();
      end
      br_ready = 0;
      repeat (3) step();
      chk("B_handshakes", hs, 4);
      chk("B_done_pulses", done_cnt - done_base, 1);

      // C: full-length map, then a new map loaded in the done cycle
      load_valid = 1; map = '1; branches = 31; br_ready = 1;
      step();
      load_valid = 0;
      repeat (31) step();
      chk("C_done", done, 1);
      load_valid = 1; map = 31'b010; branches = 3;
      step();
      load_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("C_second_taken", br_taken, seq_c[i]);
      end
      repeat (2) step();

      // D: empty map
      load_valid = 1; map = 31'h5; branches = 0;
      @(negedge clk); #1;
      chk("D_ready_before", load_ready, 1);
      step();
      load_valid = 0;
      @(negedge clk); #1;
      chk("D_done", done, 1);
      chk("D_valid", br_valid, 0);
      chk("D_load_ready", load_ready, 1);
      @(negedge clk); #1;
      chk("D_done_once", done, 0);

      // E: flush after two of five outcomes, with a load offered during the flush
      step();
      load_valid = 1; map = 31'b10110; branches = 5; br_ready = 1;
      step();
      load_valid = 0;
      step();
      step();
      br_ready = 0; flush = 1; load_valid = 1; branches = 3;
      @(negedge clk); #1;
      chk("E_ready_in_flush", load_ready, 0);
      chk("E_remaining_pre", remaining, 3);
      step();
      flush = 0; load_valid = 0;
      @(negedge clk); #1;
      chk("E_remaining", remaining, 0);
      chk("E_valid", br_valid, 0);
      chk("E_done", done, 0);
      chk("E_load_ready", load_ready, 1);
      @(negedge clk); #1;
      chk("E_no_load", br_valid, 0);
      chk("E_no_done", done, 0);

      // F: MAP_LEN=20 instance, oversize count clamps and sets err
      step();
      l20_valid = 1; map20 = '1; br20 = 31; r20_ready = 1;
      step();
      l20_valid = 0;
      chk("F_err", e20, 1);
      cnt = 0; done_seen = 0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (v20 && t20) cnt++;
         if (d20) done_seen = 1;
      end
      chk("F_outcomes", cnt, 20);
      chk("F_done_seen", done_seen, 1);
      step();
      l20_valid = 1; map20 = 20'hABCDE; br20 = 10;
      step();
      l20_valid = 0;
      step(); step();
      #1;
      chk("F_mid_replay", v20, 1);
      rst20_n = 0;
      #1;
      chk("F_rst_valid", v20, 0);
      chk("F_rst_remaining", rem20, 0);
      chk("F_rst_err", e20, 0);
      chk("F_rst_done", d20, 0);
      chk("F_rst_taken", t20, 0);
      step();
      rst20_n = 1;

      // Random phase against the model
      for (int c = 0; c < 3000; c++) begin
         rnd = $urandom;
         map = rnd[M-1:0];
         load_valid = ($urandom_range(0, 2) == 0);
         branches = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 31));
         br_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 40) == 0);
         step();
      end
      flush = 0; load_valid = 0; br_ready = 1;
      repeat (40) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
